// File: rtl/decode_pkg.sv
// Shared decode definitions: control-bundle layout, opcode/funct codes and field encodings.
// The ctrl bundle is a flat CTRL_W vector; fields are addressed LSB-first through the offsets below.
package decode_pkg;

    localparam int CTRL_W = 24;

    localparam int CTRL_SELALUSHIFT = 0;
    localparam int CTRL_SELIMREGB   = 1;
    localparam int CTRL_ALUOP       = 2;   // 3 bits
    localparam int CTRL_UNSIG       = 5;
    localparam int CTRL_SHIFTOP     = 6;   // 2 bits
    localparam int CTRL_READMEM     = 8;
    localparam int CTRL_WRITEMEM    = 9;
    localparam int CTRL_SELWSOURCE  = 10;
    localparam int CTRL_WRITEREG    = 11;
    localparam int CTRL_WRITEOV     = 12;
    localparam int CTRL_NUMOP       = 13;  // 2 bits
    localparam int CTRL_FUNUNIT     = 15;  // 2 bits
    localparam int CTRL_SELPCTYPE   = 17;  // 2 bits
    localparam int CTRL_SELBRJUMPZ  = 19;  // 2 bits
    localparam int CTRL_COMPOP      = 21;  // 3 bits

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;
    localparam logic [1:0] SH_LUI = 2'd3;

    localparam logic [1:0] FU_ALU = 2'd1;
    localparam logic [1:0] FU_MEM = 2'd2;
    localparam logic [1:0] FU_BR  = 2'd3;

    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_JIMM = 2'd2;
    localparam logic [1:0] PC_JREG = 2'd3;

    localparam logic [1:0] BJ_BRANCH = 2'd1;
    localparam logic [1:0] BJ_JUMP   = 2'd2;

    localparam logic [2:0] CMP_EQ  = 3'd1;
    localparam logic [2:0] CMP_NE  = 3'd2;
    localparam logic [2:0] CMP_LT  = 3'd3;
    localparam logic [2:0] CMP_LTU = 3'd4;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side handshake bundle of the decode queue.
// master = the queue itself, slave = the surrounding fetch/issue logic.
interface decode_queue_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic                        if_id_valid;
    logic                        if_id_ready;
    logic [DATA_W-1:0]           if_id_instruc;
    logic [DATA_W-1:0]           if_id_nextpc;
    logic                        is_ready;
    logic                        id_is_valid;
    logic [DATA_W-1:0]           id_is_instruc;
    logic [DATA_W-1:0]           id_is_nextpc;
    logic [decode_pkg::CTRL_W-1:0] id_is_ctrl;
    logic [REG_W-1:0]            id_is_addra;
    logic [REG_W-1:0]            id_is_addrb;
    logic [REG_W-1:0]            id_is_regdest;
    logic [DATA_W-1:0]           id_is_imedext;

    modport master (
        input  if_id_valid, if_id_instruc, if_id_nextpc, is_ready,
        output if_id_ready, id_is_valid, id_is_instruc, id_is_nextpc, id_is_ctrl,
               id_is_addra, id_is_addrb, id_is_regdest, id_is_imedext
    );

    modport slave (
        output if_id_valid, if_id_instruc, if_id_nextpc, is_ready,
        input  if_id_ready, id_is_valid, id_is_instruc, id_is_nextpc, id_is_ctrl,
               id_is_addra, id_is_addrb, id_is_regdest, id_is_imedext
    );
endinterface

// File: rtl/decode_ctrl_rom.sv
// Opcode/funct to control-bundle decoder; purely combinational, no flow control.
// Anything not listed decodes to an all-zero bundle (NOP).
module decode_ctrl_rom
    import decode_pkg::*;
(
    input  logic [5:0]        op_i,
    input  logic [5:0]        fn_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              selregdest_o
);

    always_comb begin
        ctrl_o       = '0;
        selregdest_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                selregdest_o                 = 1'b1;
                ctrl_o[CTRL_WRITEREG]        = 1'b1;
                ctrl_o[CTRL_NUMOP +: 2]      = 2'd2;
                ctrl_o[CTRL_FUNUNIT +: 2]    = FU_ALU;
                case (fn_i)
                    FN_SLL:  begin ctrl_o[CTRL_SELALUSHIFT] = 1'b1; ctrl_o[CTRL_SHIFTOP +: 2] = SH_SLL; end
                    FN_SRL:  begin ctrl_o[CTRL_SELALUSHIFT] = 1'b1; ctrl_o[CTRL_SHIFTOP +: 2] = SH_SRL; end
                    FN_SRA:  begin ctrl_o[CTRL_SELALUSHIFT] = 1'b1; ctrl_o[CTRL_SHIFTOP +: 2] = SH_SRA; end
                    FN_ADD:  begin ctrl_o[CTRL_ALUOP +: 3] = ALU_ADD; ctrl_o[CTRL_WRITEOV] = 1'b1; end
                    FN_ADDU: begin ctrl_o[CTRL_ALUOP +: 3] = ALU_ADD; ctrl_o[CTRL_UNSIG] = 1'b1; end
                    FN_SUB:  begin ctrl_o[CTRL_ALUOP +: 3] = ALU_SUB; ctrl_o[CTRL_WRITEOV] = 1'b1; end
                    FN_SUBU: begin ctrl_o[CTRL_ALUOP +: 3] = ALU_SUB; ctrl_o[CTRL_UNSIG] = 1'b1; end
                    FN_AND:  ctrl_o[CTRL_ALUOP +: 3] = ALU_AND;
                    FN_OR:   ctrl_o[CTRL_ALUOP +: 3] = ALU_OR;
                    FN_XOR:  ctrl_o[CTRL_ALUOP +: 3] = ALU_XOR;
                    FN_NOR:  ctrl_o[CTRL_ALUOP +: 3] = ALU_NOR;
                    FN_SLT:  begin ctrl_o[CTRL_ALUOP +: 3] = ALU_SLT; ctrl_o[CTRL_COMPOP +: 3] = CMP_LT; end
                    FN_SLTU: begin
                        ctrl_o[CTRL_ALUOP +: 3]  = ALU_SLT;
                        ctrl_o[CTRL_COMPOP +: 3] = CMP_LTU;
                        ctrl_o[CTRL_UNSIG]       = 1'b1;
                    end
                    FN_JR: begin
                        // jr writes nothing; it only redirects the PC from rs
                        ctrl_o                       = '0;
                        selregdest_o                 = 1'b0;
                        ctrl_o[CTRL_NUMOP +: 2]      = 2'd1;
                        ctrl_o[CTRL_FUNUNIT +: 2]    = FU_BR;
                        ctrl_o[CTRL_SELPCTYPE +: 2]  = PC_JREG;
                        ctrl_o[CTRL_SELBRJUMPZ +: 2] = BJ_JUMP;
                    end
                    default: begin
                        ctrl_o       = '0;
                        selregdest_o = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl_o[CTRL_SELIMREGB]    = 1'b1;
                ctrl_o[CTRL_WRITEREG]     = 1'b1;
                ctrl_o[CTRL_NUMOP +: 2]   = 2'd1;
                ctrl_o[CTRL_FUNUNIT +: 2] = FU_ALU;
                case (op_i)
                    OP_ADDI:  begin ctrl_o[CTRL_ALUOP +: 3] = ALU_ADD; ctrl_o[CTRL_WRITEOV] = 1'b1; end
                    OP_ADDIU: begin ctrl_o[CTRL_ALUOP +: 3] = ALU_ADD; ctrl_o[CTRL_UNSIG] = 1'b1; end
                    OP_SLTI:  begin ctrl_o[CTRL_ALUOP +: 3] = ALU_SLT; ctrl_o[CTRL_COMPOP +: 3] = CMP_LT; end
                    OP_SLTIU: begin ctrl_o[CTRL_ALUOP +: 3] = ALU_SLT; ctrl_o[CTRL_COMPOP +: 3] = CMP_LTU; end
                    OP_ANDI:  ctrl_o[CTRL_ALUOP +: 3] = ALU_AND;
                    OP_ORI:   ctrl_o[CTRL_ALUOP +: 3] = ALU_OR;
                    OP_XORI:  ctrl_o[CTRL_ALUOP +: 3] = ALU_XOR;
                    default:  ctrl_o[CTRL_SHIFTOP +: 2] = SH_LUI;
                endcase
            end
            OP_LW: begin
                ctrl_o[CTRL_SELIMREGB]    = 1'b1;
                ctrl_o[CTRL_ALUOP +: 3]   = ALU_ADD;
                ctrl_o[CTRL_READMEM]      = 1'b1;
                ctrl_o[CTRL_SELWSOURCE]   = 1'b1;
                ctrl_o[CTRL_WRITEREG]     = 1'b1;
                ctrl_o[CTRL_NUMOP +: 2]   = 2'd1;
                ctrl_o[CTRL_FUNUNIT +: 2] = FU_MEM;
            end
            OP_SW: begin
                ctrl_o[CTRL_SELIMREGB]    = 1'b1;
                ctrl_o[CTRL_ALUOP +: 3]   = ALU_ADD;
                ctrl_o[CTRL_WRITEMEM]     = 1'b1;
                ctrl_o[CTRL_NUMOP +: 2]   = 2'd2;
                ctrl_o[CTRL_FUNUNIT +: 2] = FU_MEM;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_o[CTRL_NUMOP +: 2]      = 2'd2;
                ctrl_o[CTRL_FUNUNIT +: 2]    = FU_BR;
                ctrl_o[CTRL_SELPCTYPE +: 2]  = PC_BR;
                ctrl_o[CTRL_SELBRJUMPZ +: 2] = BJ_BRANCH;
                ctrl_o[CTRL_COMPOP +: 3]     = (op_i == OP_BEQ) ? CMP_EQ : CMP_NE;
            end
            OP_J, OP_JAL: begin
                ctrl_o[CTRL_WRITEREG]        = (op_i == OP_JAL);
                ctrl_o[CTRL_FUNUNIT +: 2]    = FU_BR;
                ctrl_o[CTRL_SELPCTYPE +: 2]  = PC_JIMM;
                ctrl_o[CTRL_SELBRJUMPZ +: 2] = BJ_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes each accepted fetch word and enqueues it in a DEPTH-entry FIFO toward issue.
// Empty-queue latency 1 cycle; fetch sees ready=0 only when full (registered count, no path from is_ready).
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int LINK_REG = 31
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    decode_queue_if.master               bus,
    output logic [$clog2(DEPTH+1)-1:0]   id_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [REG_W-1:0] LINK = REG_W'(LINK_REG);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    logic [DATA_W-1:0] instr_mem_q  [DEPTH];
    logic [DATA_W-1:0] nextpc_mem_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_mem_q   [DEPTH];
    logic [REG_W-1:0]  addra_mem_q  [DEPTH];
    logic [REG_W-1:0]  addrb_mem_q  [DEPTH];
    logic [REG_W-1:0]  rdest_mem_q  [DEPTH];
    logic [DATA_W-1:0] imm_mem_q    [DEPTH];

    logic [DATA_W-1:0] instr;
    logic [5:0]        opcode;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_selregdest;
    logic [REG_W-1:0]  dec_regdest;
    logic [DATA_W-1:0] dec_imedext;

    assign instr  = bus.if_id_instruc;
    assign opcode = instr[31:26];

    decode_ctrl_rom u_ctrl_rom (
        .op_i         (opcode),
        .fn_i         (instr[5:0]),
        .ctrl_o       (dec_ctrl),
        .selregdest_o (dec_selregdest)
    );

    always_comb begin
        if (opcode == OP_JAL)
            dec_regdest = LINK;
        else if (dec_selregdest)
            dec_regdest = REG_W'(instr[15:11]);
        else
            dec_regdest = REG_W'(instr[20:16]);

        if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
            dec_imedext = {{(DATA_W-16){1'b0}}, instr[15:0]};
        else
            dec_imedext = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    end

    assign bus.if_id_ready = (count_q != CNT_W'(DEPTH));
    assign bus.id_is_valid = (count_q != '0);
    assign id_count        = count_q;

    assign push = bus.if_id_valid && bus.if_id_ready && !flush;
    assign pop  = bus.id_is_valid && bus.is_ready && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i]  <= '0;
                nextpc_mem_q[i] <= '0;
                ctrl_mem_q[i]   <= '0;
                addra_mem_q[i]  <= '0;
                addrb_mem_q[i]  <= '0;
                rdest_mem_q[i]  <= '0;
                imm_mem_q[i]    <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                instr_mem_q[wr_ptr_q]  <= instr;
                nextpc_mem_q[wr_ptr_q] <= bus.if_id_nextpc;
                ctrl_mem_q[wr_ptr_q]   <= dec_ctrl;
                addra_mem_q[wr_ptr_q]  <= REG_W'(instr[25:21]);
                addrb_mem_q[wr_ptr_q]  <= REG_W'(instr[20:16]);
                rdest_mem_q[wr_ptr_q]  <= dec_regdest;
                imm_mem_q[wr_ptr_q]    <= dec_imedext;
            end
        end
    end

    // Flushed entries remain in storage, so the head is masked rather than trusted.
    always_comb begin
        bus.id_is_instruc = '0;
        bus.id_is_nextpc  = '0;
        bus.id_is_ctrl    = '0;
        bus.id_is_addra   = '0;
        bus.id_is_addrb   = '0;
        bus.id_is_regdest = '0;
        bus.id_is_imedext = '0;
        if (bus.id_is_valid) begin
            bus.id_is_instruc = instr_mem_q[rd_ptr_q];
            bus.id_is_nextpc  = nextpc_mem_q[rd_ptr_q];
            bus.id_is_ctrl    = ctrl_mem_q[rd_ptr_q];
            bus.id_is_addra   = addra_mem_q[rd_ptr_q];
            bus.id_is_addrb   = addrb_mem_q[rd_ptr_q];
            bus.id_is_regdest = rdest_mem_q[rd_ptr_q];
            bus.id_is_imedext = imm_mem_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode fields, full/hold behaviour, FIFO order across wrap, flush and reset.
module tb_decode_queue;

    logic       clock;
    logic       reset;
    logic       flush;
    logic [2:0] id_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] model[$];

    decode_queue_if #(.DATA_W(32), .REG_W(5)) q_if ();

    decode_queue #(.DEPTH(4), .DATA_W(32), .REG_W(5), .LINK_REG(31)) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .bus      (q_if),
        .id_count (id_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"},   32'(q_if.id_is_valid), 32'd0);
        check({tag, "_count"},   32'(id_count), 32'd0);
        check({tag, "_ready"},   32'(q_if.if_id_ready), 32'd1);
        check({tag, "_instruc"}, q_if.id_is_instruc, 32'd0);
        check({tag, "_nextpc"},  q_if.id_is_nextpc, 32'd0);
        check({tag, "_ctrl"},    32'(q_if.id_is_ctrl), 32'd0);
        check({tag, "_addra"},   32'(q_if.id_is_addra), 32'd0);
        check({tag, "_addrb"},   32'(q_if.id_is_addrb), 32'd0);
        check({tag, "_regdest"}, 32'(q_if.id_is_regdest), 32'd0);
        check({tag, "_imedext"}, q_if.id_is_imedext, 32'd0);
    endtask

    task automatic drive(input logic vld, input logic [31:0] ins, input logic [31:0] npc);
        q_if.if_id_valid   = vld;
        q_if.if_id_instruc = ins;
        q_if.if_id_nextpc  = npc;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        q_if.is_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        check_empty("reset");

        // addi $2,$1,-1
        drive(1'b1, 32'h2022FFFF, 32'h00000004);
        tick();
        drive(1'b0, 32'd0, 32'd0);
        check("addi_valid",   32'(q_if.id_is_valid), 32'd1);
        check("addi_addra",   32'(q_if.id_is_addra), 32'd1);
        check("addi_addrb",   32'(q_if.id_is_addrb), 32'd2);
        check("addi_regdest", 32'(q_if.id_is_regdest), 32'd2);
        check("addi_imedext", q_if.id_is_imedext, 32'hFFFFFFFF);
        check("addi_count",   32'(id_count), 32'd1);
        check("addi_ctrl",    32'(q_if.id_is_ctrl), 32'h00B806);
        check("addi_nextpc",  q_if.id_is_nextpc, 32'h00000004);

        // Fill to DEPTH: ori, jal, unknown opcode
        drive(1'b1, 32'h34038000, 32'h00000008);
        tick();
        drive(1'b1, 32'h0C000010, 32'h0000000C);
        tick();
        drive(1'b1, 32'hFC001234, 32'h00000010);
        tick();
        check("full_ready", 32'(q_if.if_id_ready), 32'd0);
        check("full_count", 32'(id_count), 32'd4);

        // add $4,$5,$6 is held while full
        drive(1'b1, 32'h00A62020, 32'h00000014);
        tick();
        check("held_count", 32'(id_count), 32'd4);
        check("held_head",  q_if.id_is_instruc, 32'h2022FFFF);

        // Pop at full: the push in the same cycle is still refused
        q_if.is_ready = 1'b1;
        tick();
        q_if.is_ready = 1'b0;
        check("pop_full_count", 32'(id_count), 32'd3);
        check("pop_full_ready", 32'(q_if.if_id_ready), 32'd1);
        check("ori_instruc",    q_if.id_is_instruc, 32'h34038000);
        check("ori_imedext",    q_if.id_is_imedext, 32'h00008000);
        check("ori_regdest",    32'(q_if.id_is_regdest), 32'd3);
        tick();
        drive(1'b0, 32'd0, 32'd0);
        check("held_accept_count", 32'(id_count), 32'd4);

        // Drain and check order
        q_if.is_ready = 1'b1;
        tick();
        check("jal_instruc", q_if.id_is_instruc, 32'h0C000010);
        check("jal_regdest", 32'(q_if.id_is_regdest), 32'd31);
        check("jal_nextpc",  q_if.id_is_nextpc, 32'h0000000C);
        tick();
        check("unk_instruc", q_if.id_is_instruc, 32'hFC001234);
        check("unk_ctrl",    32'(q_if.id_is_ctrl), 32'd0);
        check("unk_imedext", q_if.id_is_imedext, 32'h00001234);
        check("unk_regdest", 32'(q_if.id_is_regdest), 32'd0);
        tick();
        check("add_instruc", q_if.id_is_instruc, 32'h00A62020);
        check("add_addra",   32'(q_if.id_is_addra), 32'd5);
        check("add_addrb",   32'(q_if.id_is_addrb), 32'd6);
        check("add_regdest", 32'(q_if.id_is_regdest), 32'd4);
        check("add_ctrl",    32'(q_if.id_is_ctrl), 32'h00D804);
        check("add_nextpc",  q_if.id_is_nextpc, 32'h00000014);
        tick();
        q_if.is_ready = 1'b0;
        check_empty("drained");

        // Steady push+pop at count=2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h20000000 | 32'(i), 32'(i * 4));
            model.push_back(32'h20000000 | 32'(i));
            tick();
        end
        check("pp_prefill_count", 32'(id_count), 32'd2);
        q_if.is_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            drive(1'b1, 32'h20000000 | 32'(i), 32'(i * 4));
            tick();
            void'(model.pop_front());
            model.push_back(32'h20000000 | 32'(i));
            check($sformatf("pp_count_%0d", i), 32'(id_count), 32'd2);
            check($sformatf("pp_head_%0d", i), q_if.id_is_instruc, model[0]);
            check($sformatf("pp_imm_%0d", i), q_if.id_is_imedext, {16'd0, model[0][15:0]});
        end
        q_if.is_ready = 1'b0;
        drive(1'b1, 32'h20000055, 32'h00000100);
        tick();
        check("pre_flush_count", 32'(id_count), 32'd3);

        // Flush with a concurrent push and pop request
        flush = 1'b1;
        q_if.is_ready = 1'b1;
        drive(1'b1, 32'hDC00BEEF, 32'h00000104);
        tick();
        flush = 1'b0;
        q_if.is_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        check_empty("flush");
        tick();
        check("post_flush_count", 32'(id_count), 32'd0);
        check("post_flush_valid", 32'(q_if.id_is_valid), 32'd0);

        // Reset mid-traffic from a full queue
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h20000100 + 32'(i), 32'h00000200 + 32'(i * 4));
            tick();
        end
        drive(1'b0, 32'd0, 32'd0);
        check("pre_reset_count", 32'(id_count), 32'd4);
        reset = 1'b1;
        q_if.is_ready = 1'b1;
        tick();
        reset = 1'b0;
        q_if.is_ready = 1'b0;
        check_empty("midreset");
        drive(1'b1, 32'h34038000, 32'h00000300);
        tick();
        drive(1'b0, 32'd0, 32'd0);
        check("post_reset_valid",   32'(q_if.id_is_valid), 32'd1);
        check("post_reset_instruc", q_if.id_is_instruc, 32'h34038000);
        check("post_reset_imedext", q_if.id_is_imedext, 32'h00008000);
        check("post_reset_count",   32'(id_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised decode stage between fetch (if_id_*) and issue (id_is_*).
- Decodes each accepted instruction combinationally into a control bundle, register addresses and an extended immediate, then enqueues the result in a DEPTH-entry queue.
- Issue drains the queue through a valid/ready handshake. This replaces the single-register stall scheme and absorbs issue back-pressure without stalling fetch until the queue is full.
- A synchronous flush empties the queue on branch mispredict.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- DATA_W, 32, instruction and PC width.
- REG_W, 5, register-address width.
- LINK_REG, 31, destination register forced for jal.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous queue clear; priority over push and pop.
- if_id_valid  in  1  fetch presents an instruction.
- if_id_ready  out  1  queue can accept: count < DEPTH.
- if_id_instruc  in  DATA_W  instruction word.
- if_id_nextpc  in  DATA_W  PC+4 of the instruction.
- is_ready  in  1  issue consumes the head entry this cycle.
- id_is_valid  out  1  head entry valid (count != 0).
- id_is_instruc  out  DATA_W  head instruction.
- id_is_nextpc  out  DATA_W  head next-PC.
- id_is_ctrl  out  CTRL_W (24)  packed control bundle; layout in package.
- id_is_addra  out  REG_W  rs = instr[25:21].
- id_is_addrb  out  REG_W  rt = instr[20:16].
- id_is_regdest  out  REG_W  destination register.
- id_is_imedext  out  DATA_W  extended immediate.
- id_count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Push condition: if_id_valid && if_id_ready && !flush.
- Pop condition: id_is_valid && is_ready && !flush.
- Push and pop in the same cycle are both performed; count is unchanged.
- if_id_ready depends only on registered count. There is no combinational path from is_ready, so a full queue with a same-cycle pop still refuses the push.
- Latency: an instruction pushed in cycle N is visible at the head in N+1 if the queue was empty. Queue order is strict FIFO.
- Head outputs are read from storage at rd_ptr. All id_is_* data fields are driven to 0 whenever id_is_valid=0.
- Pointers are log2(DEPTH) bits and wrap naturally; count ranges 0..DEPTH.
- Reset: rd_ptr=wr_ptr=count=0 and storage cleared.
  - Outputs after reset: id_is_valid=0, all id_is_* fields=0, id_count=0, if_id_ready=1.
  - Reset mid-traffic discards all entries; no output glitch beyond the cycle boundary.
- Flush has the same pointer effect as reset (storage is not cleared). An instruction presented during the flush cycle is dropped, and is_ready in that cycle is ignored.
- Decode rules, applied at push:
  - ctrl comes from the opcode/funct decoder (sub-module).
  - regdest = instr[15:11] if selregdest, else instr[20:16].
  - Exception: opcode 6'h03 (jal) forces regdest=LINK_REG.
  - imedext is zero-extended for opcodes 6'h0C, 6'h0D, 6'h0E (andi/ori/xori) and sign-extended for all others.
- Unknown opcodes decode to an all-zero ctrl (NOP). They are still enqueued and passed through.

Decomposition:
- Package decode_pkg holds:
  - CTRL_W=24.
  - Field offsets for the ctrl bundle, LSB first: selalushift, selimregb, aluop[3], unsig, shiftop[2], readmem, writemem, selwsource, writereg, writeov, numop[2], fununit[2], selpctype[2], selbrjumpz[2], compop[3].
  - Opcode constants OP_RTYPE, OP_JAL, OP_ANDI, OP_ORI, OP_XORI.
- Sub-module decode_ctrl_rom: purely combinational; inputs op[5:0] and fn[5:0]; outputs the ctrl bundle and selregdest.
- Queue storage and pointers stay in decode_queue.

Test Plan:
- Reset, then push addi $2,$1,-1 (32'h2022FFFF) with is_ready=0 → next cycle id_is_valid=1, addra=1, addrb=2, regdest=2, imedext=32'hFFFFFFFF, id_count=1.
- DEPTH=4 with is_ready=0: push 5 instructions back to back → if_id_ready=0 after the 4th; the 5th is held; id_count=4. Raise is_ready for one cycle → head pops, the held instruction is accepted the following cycle, order is preserved.
- ori $3,$0,0x8000 → imedext=32'h00008000. jal → regdest=31.
- Simultaneous push and pop at count=2 for 10 cycles → id_count stays 2. Outputs match a reference FIFO model across pointer wrap.
- flush at count=3 together with if_id_valid=1 → next cycle id_count=0, id_is_valid=0, all fields 0; the flushed-cycle instruction never appears.
- Assert reset with count=4 and is_ready=1 → next cycle all outputs zero and if_id_ready=1. The first post-reset push appears at the head after 1 cycle.
